// File: rtl/pb_io_peripheral.sv
// pb_io_peripheral: PicoBlaze-style I/O peripheral with GPIO, a receive FIFO,
// a sticky overflow flag and a registered interrupt request FSM.
// Optional feature macro: PB_IO_OVERFLOW_IRQ_EN (adds IRQ_EN[1], overflow irq).
//
// Receive handshake: a byte moves from the producer into the FIFO at a rising
// edge where ext_rx_valid and ext_rx_ready are both high; ext_rx_ready is
// simply "FIFO not full" from the registered count. A valid byte offered while
// full is dropped and raises the sticky overflow flag.
module pb_io_peripheral #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic       read_strobe,
  input  logic [7:0] out_port,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       interrupt_ack,
  input  logic [7:0] ext_rx_data,
  input  logic       ext_rx_valid,
  output logic       ext_rx_ready,
  output logic [7:0] gpio_out,
  input  logic [7:0] gpio_in,
  output logic [1:0] irq_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    HOLDOFF = 2'd2
  } irq_state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [1:0]    irq_en;
  logic          empty, full, push, pop, ovf_set, ovf_clr;
  logic          wr_gpio, wr_status, wr_irqen;
  logic [7:0]    status, rd_mux, irqen_rd;
  logic [3:0]    count_ext;
  logic          irq_cond;
  irq_state_t    state_q, state_d;
  logic          hold_q, hold_d;

  assign empty        = (count == '0);
  assign full         = (count == CW'(FIFO_DEPTH));
  assign ext_rx_ready = ~full;
  assign push         = ext_rx_valid & ~full & ~reset;
  assign ovf_set      = ext_rx_valid & full;
  assign pop          = read_strobe & (port_id == 8'h02) & ~empty;
  assign wr_gpio      = write_strobe & (port_id == 8'h00);
  assign wr_status    = write_strobe & (port_id == 8'h03);
  assign wr_irqen     = write_strobe & (port_id == 8'h04);
  assign ovf_clr      = wr_status & out_port[2];
  assign count_ext    = 4'(count);
  assign status       = {count_ext, 1'b0, overflow, full, empty};
  assign irqen_rd     = {6'd0, irq_en};
  assign irq_cond     = (irq_en[0] & ~empty) | (irq_en[1] & overflow);
  assign interrupt    = (state_q == PEND);
  assign irq_state    = state_q;

  // FIFO storage: write the incoming byte at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ext_rx_data;
  end

  // FIFO pointers, occupancy count and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new overflow event wins over a same-cycle clear.
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Processor-writable registers; IRQ_EN[1] only exists with the feature macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out <= 8'h00;
      irq_en   <= 2'b00;
    end else begin
      if (wr_gpio) gpio_out <= out_port;
`ifdef PB_IO_OVERFLOW_IRQ_EN
      if (wr_irqen) irq_en <= out_port[1:0];
`else
      if (wr_irqen) irq_en <= {1'b0, out_port[0]};
`endif
    end
  end

  // Read mux by port_id; RX_DATA shows the head, or zero when empty.
  always_comb begin
    rd_mux = 8'h00;
    case (port_id)
      8'h00:   rd_mux = gpio_out;
      8'h01:   rd_mux = gpio_in;
      8'h02:   rd_mux = empty ? 8'h00 : mem[rd_ptr];
      8'h03:   rd_mux = status;
      8'h04:   rd_mux = irqen_rd;
      default: rd_mux = 8'h00;
    endcase
  end

  // in_port is loaded every cycle from the mux, independent of read_strobe.
  always_ff @(posedge clk) begin
    if (reset) in_port <= 8'h00;
    else       in_port <= rd_mux;
  end

  // IRQ FSM state register plus the two-cycle holdoff phase bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // IRQ FSM next state: a raised request stays up until acknowledged.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (irq_cond) state_d = PEND;
      end
      PEND: begin
        if (interrupt_ack) begin
          state_d = HOLDOFF;
          hold_d  = 1'b0;
        end
      end
      HOLDOFF: begin
        hold_d = 1'b1;
        if (hold_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pb_io_peripheral.sv
// tb_pb_io_peripheral: directed bench for pb_io_peripheral with a queue-based
// reference model compared against the DUT on every cycle after reset.
module tb_pb_io_peripheral;

  localparam int D = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] port_id = 8'h00;
  logic       write_strobe = 1'b0;
  logic       read_strobe = 1'b0;
  logic [7:0] out_port = 8'h00;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack = 1'b0;
  logic [7:0] ext_rx_data = 8'h00;
  logic       ext_rx_valid = 1'b0;
  logic       ext_rx_ready;
  logic [7:0] gpio_out;
  logic [7:0] gpio_in = 8'h00;
  logic [1:0] irq_state;

  always #5 clk = ~clk;

  pb_io_peripheral #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .port_id(port_id), .write_strobe(write_strobe),
    .read_strobe(read_strobe), .out_port(out_port), .in_port(in_port),
    .interrupt(interrupt), .interrupt_ack(interrupt_ack),
    .ext_rx_data(ext_rx_data), .ext_rx_valid(ext_rx_valid),
    .ext_rx_ready(ext_rx_ready), .gpio_out(gpio_out), .gpio_in(gpio_in),
    .irq_state(irq_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%02h exp=%02h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] exp_q[$];
  logic       m_ovf, m_irq, m_live = 1'b0;
  logic [7:0] m_gpio, m_in;
  logic [1:0] m_irqen;
  int         m_hold;
  logic [7:0] m_rd;
  logic       m_cond;
  int         m_n;
`ifdef PB_IO_OVERFLOW_IRQ_EN
  localparam logic [1:0] IRQEN_MASK = 2'b11;
`else
  localparam logic [1:0] IRQEN_MASK = 2'b01;
`endif

  always @(posedge clk) begin
    m_n = exp_q.size();
    if (reset) begin
      exp_q.delete();
      m_ovf = 1'b0; m_irq = 1'b0; m_gpio = 8'h00; m_in = 8'h00;
      m_irqen = 2'b00; m_hold = 0; m_live = 1'b1;
    end else begin
      case (port_id)
        8'h00:   m_rd = m_gpio;
        8'h01:   m_rd = gpio_in;
        8'h02:   m_rd = (m_n > 0) ? exp_q[0] : 8'h00;
        8'h03:   m_rd = {m_n[3:0], 1'b0, m_ovf, (m_n == D), (m_n == 0)};
        8'h04:   m_rd = {6'd0, m_irqen};
        default: m_rd = 8'h00;
      endcase
      m_cond = (m_irqen[0] && m_n > 0) || (m_irqen[1] && m_ovf);
      // interrupt: raised when idle and condition holds; after an ack it is
      // quiet for two holdoff cycles before being allowed to rise again
      if (m_hold > 0)             m_hold = m_hold - 1;
      else if (m_irq) begin
        if (interrupt_ack) begin m_irq = 1'b0; m_hold = 2; end
      end else if (m_cond)        m_irq = 1'b1;
      if (read_strobe && port_id == 8'h02 && m_n > 0) void'(exp_q.pop_front());
      if (ext_rx_valid && m_n < D) exp_q.push_back(ext_rx_data);
      if (ext_rx_valid && m_n == D) m_ovf = 1'b1;
      else if (write_strobe && port_id == 8'h03 && out_port[2]) m_ovf = 1'b0;
      if (write_strobe && port_id == 8'h00) m_gpio = out_port;
      if (write_strobe && port_id == 8'h04) m_irqen = out_port[1:0] & IRQEN_MASK;
      m_in = m_rd;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_live) begin
      check("model_in_port", in_port, m_in);
      check("model_gpio_out", gpio_out, m_gpio);
      check("model_interrupt", {7'd0, interrupt}, {7'd0, m_irq});
      check("model_rx_ready", {7'd0, ext_rx_ready}, {7'd0, (exp_q.size() != D)});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_port(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); port_id = a; out_port = d; write_strobe = 1'b1;
    @(negedge clk); write_strobe = 1'b0;
  endtask

  task automatic read_port(input logic [7:0] a, input logic [7:0] exp, input string name);
    @(negedge clk); port_id = a; read_strobe = 1'b1;
    @(negedge clk); read_strobe = 1'b0;
    check(name, in_port, exp);
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk); ext_rx_data = b; ext_rx_valid = 1'b1;
    @(negedge clk); ext_rx_valid = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk); interrupt_ack = 1'b1;
    @(negedge clk); interrupt_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bit seen;
    idle(2);
    reset = 1'b0;
    check("reset_gpio_out", gpio_out, 8'h00);
    check("reset_in_port", in_port, 8'h00);
    check("reset_interrupt", {7'd0, interrupt}, 8'h00);
    idle(1);
    check("ready_after_reset", {7'd0, ext_rx_ready}, 8'h01);

    // GPIO out/in and unmapped addresses
    write_port(8'h00, 8'hA5);
    check("gpio_out_a5", gpio_out, 8'hA5);
    read_port(8'h00, 8'hA5, "read_gpio_out");
    gpio_in = 8'h3C;
    read_port(8'h01, 8'h3C, "read_gpio_in");
    write_port(8'h07, 8'hFF);
    check("unmapped_write_ignored", gpio_out, 8'hA5);
    read_port(8'h07, 8'h00, "unmapped_read");

    // three-byte FIFO round trip
    push(8'h11); push(8'h22); push(8'h33);
    read_port(8'h03, 8'h30, "status_three");
    read_port(8'h02, 8'h11, "rx_11");
    read_port(8'h02, 8'h22, "rx_22");
    read_port(8'h02, 8'h33, "rx_33");
    read_port(8'h03, 8'h01, "status_empty");
    read_port(8'h02, 8'h00, "rx_empty_reads_zero");

    // fill, overflow, clear overflow, drain
    for (int i = 0; i < 9; i++) begin
      push(8'h40 + 8'(i));
      if (i == 7) check("ready_low_when_full", {7'd0, ext_rx_ready}, 8'h00);
    end
    read_port(8'h03, 8'h86, "status_full_ovf");
    write_port(8'h03, 8'h04);
    read_port(8'h03, 8'h82, "status_ovf_cleared");
    for (int i = 0; i < 8; i++) read_port(8'h02, 8'h40 + 8'(i), "rx_drain");
    read_port(8'h03, 8'h01, "status_after_drain");

    // simultaneous push and pop at count 4
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    @(negedge clk);
    port_id = 8'h02; read_strobe = 1'b1; ext_rx_data = 8'h5A; ext_rx_valid = 1'b1;
    @(negedge clk);
    read_strobe = 1'b0; ext_rx_valid = 1'b0;
    check("pushpop_head", in_port, 8'hA1);
    read_port(8'h03, 8'h40, "pushpop_count4");
    read_port(8'h02, 8'hA2, "pushpop_a2");
    read_port(8'h02, 8'hA3, "pushpop_a3");
    read_port(8'h02, 8'hA4, "pushpop_a4");
    read_port(8'h02, 8'h5A, "pushpop_tail_5a");

    // non-empty interrupt, ack, holdoff, reassert, no withdrawal
    ack();
    check("ack_idle_ignored", {7'd0, interrupt}, 8'h00);
    write_port(8'h04, 8'h01);
    read_port(8'h04, 8'h01, "irqen_01");
    push(8'h77);
    idle(1);
    check("irq_after_push", {7'd0, interrupt}, 8'h01);
    idle(3);
    check("irq_held", {7'd0, interrupt}, 8'h01);
    ack();
    check("irq_low_after_ack0", {7'd0, interrupt}, 8'h00);
    idle(1);
    check("irq_low_after_ack1", {7'd0, interrupt}, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      idle(1);
      if (interrupt) seen = 1'b1;
    end
    check("irq_reassert", {7'd0, seen}, 8'h01);
    read_port(8'h02, 8'h77, "rx_77");
    check("irq_no_withdraw", {7'd0, interrupt}, 8'h01);
    ack();
    idle(6);
    check("irq_stays_low_empty", {7'd0, interrupt}, 8'h00);

    // overflow interrupt enable
    write_port(8'h04, 8'h02);
`ifdef PB_IO_OVERFLOW_IRQ_EN
    read_port(8'h04, 8'h02, "irqen_02");
`else
    read_port(8'h04, 8'h00, "irqen_02_absent");
`endif
    for (int i = 0; i < 9; i++) push(8'hC0 + 8'(i));
    idle(3);
`ifdef PB_IO_OVERFLOW_IRQ_EN
    check("ovf_irq", {7'd0, interrupt}, 8'h01);
`else
    check("ovf_no_irq", {7'd0, interrupt}, 8'h00);
`endif
    read_port(8'h03, 8'h86, "status_ovf_again");

    // reset mid-transfer with strobes active
    @(negedge clk);
    reset = 1'b1; port_id = 8'h00; out_port = 8'hFF; write_strobe = 1'b1; ext_rx_valid = 1'b1;
    idle(2);
    reset = 1'b0; write_strobe = 1'b0; ext_rx_valid = 1'b0;
    check("midreset_gpio", gpio_out, 8'h00);
    check("midreset_irq", {7'd0, interrupt}, 8'h00);
    check("midreset_ready", {7'd0, ext_rx_ready}, 8'h01);
    read_port(8'h03, 8'h01, "midreset_status");
    read_port(8'h04, 8'h00, "midreset_irqen");
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pb_io_peripheral.md
PB_IO_PERIPHERAL -- requirements
Module: pb_io_peripheral

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, receive FIFO depth in entries; legal values 2, 4, 8.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 port_id  input  8  processor I/O address.
REQ-005 write_strobe  input  1  processor OUTPUT strobe, one cycle.
REQ-006 read_strobe  input  1  processor INPUT strobe, one cycle.
REQ-007 out_port  input  8  write data from processor.
REQ-008 in_port  output  8  read data to processor.
REQ-009 interrupt  output  1  interrupt request to processor.
REQ-010 interrupt_ack  input  1  interrupt acknowledge from processor.
REQ-011 ext_rx_data  input  8  byte from external producer.
REQ-012 ext_rx_valid  input  1  producer has a byte.
REQ-013 ext_rx_ready  output  1  FIFO can accept; transfer when valid and ready both high at an edge.
REQ-014 gpio_out  output  8  general-purpose output register.
REQ-015 gpio_in  input  8  general-purpose input pins.

Function
REQ-016 Port map: 0x00 GPIO_OUT (R/W), 0x01 GPIO_IN (R), 0x02 RX_DATA (R, pops), 0x03 STATUS (R/W1C), 0x04 IRQ_EN (R/W, bits 1:0); all other addresses read 0x00, writes ignored.
REQ-017 STATUS: bit0 empty, bit1 full, bit2 overflow (sticky), bit3 0, bits 7:4 occupancy count.
REQ-018 Write decode: at an edge with write_strobe=1, the addressed register takes out_port; writing 0x03 with bit2=1 clears overflow.
REQ-019 in_port is registered: each edge it loads the mux of port_id (one-cycle latency), independent of read_strobe.
REQ-020 RX_DATA read value is FIFO head; reads 0x00 when empty.
REQ-021 Pop occurs at the edge where read_strobe=1 and port_id=0x02 and FIFO not empty; pop of empty FIFO changes nothing.
REQ-022 ext_rx_ready = not full (combinational from registered count).
REQ-023 Push and pop at the same edge both occur; count unchanged; FIFO not full so push is legal.
REQ-024 ext_rx_valid=1 while full sets overflow at that edge; byte discarded; FIFO contents unchanged.
REQ-025 Read/write pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-026 IRQ condition = (IRQ_EN[0] and not empty) or (IRQ_EN[1] and overflow).
REQ-027 IRQ FSM states IDLE, PEND, HOLDOFF; interrupt=1 only in PEND (registered).
REQ-028 IDLE->PEND at edge where condition true; PEND->HOLDOFF at edge where interrupt_ack=1; HOLDOFF lasts exactly 2 cycles then ->IDLE.
REQ-029 PEND persists even if condition drops before ack (no request withdrawal).
REQ-030 interrupt_ack outside PEND is ignored.

Reset
REQ-031 At an edge with reset=1: gpio_out=0x00, in_port=0x00, IRQ_EN=0, overflow=0, FIFO empty (pointers and count 0), FSM=IDLE, interrupt=0.
REQ-032 Reset mid-transfer discards FIFO contents and any pending interrupt; strobes during reset ignored.
REQ-033 ext_rx_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-034 Macro PB_IO_OVERFLOW_IRQ_EN: when defined, IRQ_EN[1] is implemented per REQ-026.
REQ-035 When undefined, IRQ_EN[1] is not stored, reads 0, and overflow never raises interrupt; overflow flag and STATUS bit2 still function.

Verification
REQ-036 Reset, then OUTPUT 0xA5 to 0x00 -> gpio_out=0xA5 next cycle; INPUT 0x00 returns 0xA5.
REQ-037 Push 0x11,0x22,0x33; STATUS reads 0x30; three RX_DATA reads return 0x11,0x22,0x33; STATUS then 0x01.
REQ-038 Push 9 bytes with FIFO_DEPTH=8 -> ext_rx_ready=0 after 8th, STATUS=0x86; write 0x04 to 0x03 -> STATUS=0x82.
REQ-039 IRQ_EN=0x01, push one byte -> interrupt=1 next cycle, held until interrupt_ack; low 2 cycles after ack, reasserts if FIFO still non-empty.
REQ-040 FIFO at count 4, simultaneous push 0x5A and RX_DATA pop -> count stays 4, 0x5A enters at tail, head returned.
REQ-041 Overflow with IRQ_EN=0x02 -> interrupt=1 when PB_IO_OVERFLOW_IRQ_EN defined; interrupt stays 0 and IRQ_EN reads 0x00 when undefined.
